// File: rtl/hamming_display_ctrl.sv
// Display output stage for the Hamming(7,4) decoder: debounces the mode
// button and time-multiplexes two active-low 7-segment digits.
module hamming_display_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_CYCLES  = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic [3:0] word_corr,
    input  logic [2:0] sindrome,
    output logic [6:0] seg,
    output logic [1:0] anodo,
    output logic       mode,
    output logic       btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;
    localparam logic [6:0]    SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic          r_sync1, r_sync2;
    logic          w_btn_s;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_mode, w_mode_nxt;
    logic          r_pulse, w_pulse_nxt;
    logic [RW-1:0] r_rcnt;
    logic          r_sel;
    logic [6:0]    w_right, w_left, w_seg_nxt;
    logic [6:0]    r_seg;
    logic [1:0]    r_anodo;

    // Segment pattern {g..a}, active-low, for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;

    // Debounce FSM state, counter, mode and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Debounce next-state: a level must hold DEBOUNCE_CYCLES more cycles to be accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_pulse_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_pulse_nxt = 1'b1;
                    w_mode_nxt  = ~r_mode;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                // A bounce back high during release is still the same press.
                if (w_btn_s) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Refresh timer: sel flips each time rcnt wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt <= '0;
            r_sel  <= 1'b0;
        end else if (r_rcnt == RCNT_LAST) begin
            r_rcnt <= '0;
            r_sel  <= ~r_sel;
        end else begin
            r_rcnt <= r_rcnt + RW'(1);
        end
    end

    // Digit content for the current view; sel=0 lights the right digit.
    always_comb begin
        w_right = hex7(word_corr);
        w_left  = SEG_BLANK;
        if (r_mode) begin
            w_right = hex7({1'b0, sindrome});
            w_left  = (sindrome != 3'd0) ? SEG_E : SEG_BLANK;
        end
        w_seg_nxt = r_sel ? w_left : w_right;
    end

    // Registered segment and anode drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= SEG_BLANK;
            r_anodo <= 2'b11;
        end else begin
            r_seg   <= w_seg_nxt;
            r_anodo <= r_sel ? 2'b01 : 2'b10;
        end
    end

    assign seg       = r_seg;
    assign anodo     = r_anodo;
    assign mode      = r_mode;
    assign btn_pulse = r_pulse;

endmodule
